// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and helpers for the EX-stage RV32M multiply/divide sequencer.
// Op encodings follow funct3 of the M-extension instructions.
package ex_muldiv_sequencer_pkg;

    localparam int unsigned MDU_DEFAULT_WIDTH = 32;
    localparam int unsigned MDU_CYCLES        = MDU_DEFAULT_WIDTH;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic rs1_is_signed(input muldiv_op_e op);
        case (op)
            MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: rs1_is_signed = 1'b1;
            default:                                    rs1_is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic rs2_is_signed(input muldiv_op_e op);
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: rs2_is_signed = 1'b1;
            default:                         rs2_is_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_mdu_sign_fix.sv
// Combinational conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of the final product/quotient/remainder.
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide sharing one
// hi/lo register pair, stalling the pipeline until the result is presented.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned         CW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]       CNT_LOAD = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mdu_state_e             state_r, state_nx;
    logic [CW-1:0]          cnt_r, cnt_nx;
    muldiv_op_e             op_r, op_nx;
    logic                   sign_a_r, sign_a_nx;
    logic                   sign_b_r, sign_b_nx;
    logic [DATA_WIDTH-1:0]  hi_r, hi_nx;
    logic [DATA_WIDTH-1:0]  lo_r, lo_nx;
    logic [DATA_WIDTH-1:0]  b_r, b_nx;
    logic [DATA_WIDTH-1:0]  result_r, result_nx;

    muldiv_op_e             op_in_s;
    logic                   sa_in_s, sb_in_s;
    logic [DATA_WIDTH-1:0]  mag_a_s, mag_b_s;
    logic                   div_zero_s, overflow_s;
    logic [DATA_WIDTH-1:0]  special_res_s;

    logic [DATA_WIDTH:0]    mul_sum_s;
    logic [DATA_WIDTH:0]    div_shift_s, div_diff_s;
    logic                   div_take_s;
    logic [DATA_WIDTH-1:0]  iter_hi_s, iter_lo_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [DATA_WIDTH-1:0]  quo_s, rem_s, final_s;

    assign op_in_s = muldiv_op_e'(funct3_i);
    assign sa_in_s = operand1_i[DATA_WIDTH-1] & rs1_is_signed(op_in_s);
    assign sb_in_s = operand2_i[DATA_WIDTH-1] & rs2_is_signed(op_in_s);

    mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_mag_a (.value(operand1_i), .negate(sa_in_s), .result(mag_a_s));
    mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_mag_b (.value(operand2_i), .negate(sb_in_s), .result(mag_b_s));

    // Divide corner cases resolved at accept time without iterating
    always_comb begin
        div_zero_s    = funct3_i[2] & (operand2_i == '0);
        overflow_s    = funct3_i[2] & ~funct3_i[0] & (operand1_i == MIN_NEG) & (operand2_i == ALL_ONES);
        special_res_s = '0;
        if (div_zero_s) begin
            special_res_s = funct3_i[1] ? operand1_i : ALL_ONES;
        end else if (overflow_s) begin
            special_res_s = funct3_i[1] ? '0 : MIN_NEG;
        end else begin
            special_res_s = '0;
        end
    end

    // One shift-add or restoring-divide step on the shared hi/lo pair
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : '0)};
        div_shift_s = {hi_r, lo_r[DATA_WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        div_take_s  = ~div_diff_s[DATA_WIDTH];
        if (op_r[2]) begin
            iter_hi_s = div_take_s ? div_diff_s[DATA_WIDTH-1:0] : div_shift_s[DATA_WIDTH-1:0];
            iter_lo_s = {lo_r[DATA_WIDTH-2:0], div_take_s};
        end else begin
            iter_hi_s = mul_sum_s[DATA_WIDTH:1];
            iter_lo_s = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
        end
    end

    mdu_sign_fix #(.WIDTH(2*DATA_WIDTH)) u_fix_prod (.value({iter_hi_s, iter_lo_s}), .negate(sign_a_r ^ sign_b_r), .result(prod_s));
    mdu_sign_fix #(.WIDTH(DATA_WIDTH))   u_fix_quo  (.value(iter_lo_s), .negate(sign_a_r ^ sign_b_r), .result(quo_s));
    mdu_sign_fix #(.WIDTH(DATA_WIDTH))   u_fix_rem  (.value(iter_hi_s), .negate(sign_a_r), .result(rem_s));

    // Final result select from the last iteration's sign-corrected values
    always_comb begin
        case (op_r)
            MD_MUL:                        final_s = prod_s[DATA_WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            MD_DIV, MD_DIVU:               final_s = quo_s;
            MD_REM, MD_REMU:               final_s = rem_s;
            default:                       final_s = '0;
        endcase
    end

    // Next-state logic for the FSM, counter and datapath registers
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        op_nx     = op_r;
        sign_a_nx = sign_a_r;
        sign_b_nx = sign_b_r;
        hi_nx     = hi_r;
        lo_nx     = lo_r;
        b_nx      = b_r;
        result_nx = result_r;
        case (state_r)
            MDU_IDLE: begin
                if (start_i && !flush_i) begin
                    op_nx     = op_in_s;
                    sign_a_nx = sa_in_s;
                    sign_b_nx = sb_in_s;
                    hi_nx     = '0;
                    lo_nx     = mag_a_s;
                    b_nx      = mag_b_s;
                    if (div_zero_s || overflow_s) begin
                        state_nx  = MDU_DONE;
                        cnt_nx    = '0;
                        result_nx = special_res_s;
                    end else begin
                        state_nx  = MDU_CALC;
                        cnt_nx    = CNT_LOAD;
                    end
                end else begin
                    state_nx = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                hi_nx  = iter_hi_s;
                lo_nx  = iter_lo_s;
                cnt_nx = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_nx  = MDU_DONE;
                    result_nx = final_s;
                end else begin
                    state_nx  = MDU_CALC;
                end
            end
            MDU_DONE: begin
                state_nx = MDU_IDLE;
            end
            default: begin
                state_nx = MDU_IDLE;
                cnt_nx   = '0;
            end
        endcase
        // A flushed op must never surface a result, even on its final step
        if (flush_i) begin
            state_nx  = MDU_IDLE;
            cnt_nx    = '0;
            result_nx = result_r;
        end else begin
            state_nx  = state_nx;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MDU_IDLE;
            cnt_r    <= '0;
            op_r     <= MD_MUL;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            b_r      <= '0;
            result_r <= '0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            op_r     <= op_nx;
            sign_a_r <= sign_a_nx;
            sign_b_r <= sign_b_nx;
            hi_r     <= hi_nx;
            lo_r     <= lo_nx;
            b_r      <= b_nx;
            result_r <= result_nx;
        end
    end

    assign stall_o  = ((state_r == MDU_IDLE) & start_i & ~flush_i) | (state_r == MDU_CALC);
    assign busy_o   = (state_r != MDU_IDLE);
    assign done_o   = (state_r == MDU_DONE);
    assign result_o = result_r;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed and randomized M-ops
// compared against an arithmetic reference, plus flush and reset scenarios.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [2:0]    funct3_i = 3'd0;
    logic [W-1:0]  operand1_i = '0;
    logic [W-1:0]  operand2_i = '0;
    logic          flush_i = 1'b0;
    logic          stall_o, busy_o, done_o;
    logic [W-1:0]  result_o;

    int checks = 0;
    int passes = 0;

    ex_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .operand1_i(operand1_i), .operand2_i(operand2_i), .flush_i(flush_i),
        .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // RV32M semantics from plain signed/unsigned 64-bit arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res, got;
        int          exp_lat, done_cyc, stall_cnt;
        logic        special;
        exp_res   = ref_md(f3, a, b);
        special   = f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat   = special ? 2 : W + 2;
        done_cyc  = -1;
        stall_cnt = 0;
        got       = '0;
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b0; funct3_i = f3; operand1_i = a; operand2_i = b;
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            #1;
            if (stall_o) stall_cnt++;
            if (done_o) begin
                done_cyc = cyc;
                got      = result_o;
            end else begin
                @(negedge clk);
                operand1_i = $urandom();
                operand2_i = $urandom();
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checks++;
        if (done_cyc !== exp_lat - 1) $display("FAIL done_cycle f3=%0d a=%h b=%h: got %0d want %0d", f3, a, b, done_cyc, exp_lat - 1);
        else passes++;
        checks++;
        if (got !== exp_res) $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, got, exp_res);
        else passes++;
        checks++;
        if (stall_cnt !== exp_lat - 1) $display("FAIL stall_cycles f3=%0d a=%h b=%h: got %0d want %0d", f3, a, b, stall_cnt, exp_lat - 1);
        else passes++;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL idle_after f3=%0d: got busy=%b done=%b want 0 0", f3, busy_o, done_o);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'd0)
            $display("FAIL reset_state: got stall=%b busy=%b done=%b result=%h want 0 0 0 0", stall_o, busy_o, done_o, result_o);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd100, 32'd0);
        run_op(3'd7, 32'd100, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          r;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            else b = b;
            run_op(f3, a, b);
        end
    endtask

    task automatic test_flush();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b0; funct3_i = 3'd4;
        operand1_i = $urandom(); operand2_i = $urandom() | 32'd1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            #1;
            if (done_o) seen_done++;
            @(negedge clk);
            operand1_i = $urandom();
        end
        #1;
        checks++;
        if (stall_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL flush_precond: got stall=%b busy=%b want 1 1", stall_o, busy_o);
        else passes++;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL flush_idle: got busy=%b stall=%b want 0 0", busy_o, stall_o);
        else passes++;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (done_o) seen_done++;
        end
        checks++;
        if (seen_done !== 0) $display("FAIL flush_no_done: got %0d done cycles want 0", seen_done);
        else passes++;
    endtask

    task automatic test_start_flush();
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0;
        operand1_i = 32'd5; operand2_i = 32'd6;
        #1;
        checks++;
        if (stall_o !== 1'b0) $display("FAIL start_flush_stall: got %b want 0", stall_o);
        else passes++;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL start_flush_accept: got busy=%b done=%b want 0 0", busy_o, done_o);
        else passes++;
        run_op(3'd0, 32'd5, 32'd6);
    endtask

    task automatic test_reset_mid();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd0; operand1_i = $urandom(); operand2_i = $urandom();
        for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
        #2;
        rst_n = 1'b0; start_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'd0)
            $display("FAIL reset_mid: got stall=%b busy=%b done=%b result=%h want 0 0 0 0", stall_o, busy_o, done_o, result_o);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd3, 32'd4);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_start_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ops sitting beside the EX-stage ALU.
- Accepts an M-op in EX and runs an iterative shift-add multiply or a restoring divide.
- Holds the pipeline via stall_o until the result is ready; the EX stage muxes result_o onto the EX/MEM alu_result when done_o is high.

Parameters:
- DATA_WIDTH, 32, operand/result width. Counter width is $clog2(DATA_WIDTH)+1.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  valid M-op present in EX (decoder funct7=0000001, opcode OP)
- funct3_i  input  3  M-op select (instruction[14:12])
- operand1_i  input  DATA_WIDTH  rs1 after forwarding
- operand2_i  input  DATA_WIDTH  rs2 after forwarding
- flush_i  input  1  kill in-flight op (branch/jump flush, trap)
- stall_o  output  1  freeze PC, IF/ID and ID/EX; bubble EX/MEM
- busy_o  output  1  state != IDLE
- done_o  output  1  result_o valid this cycle
- result_o  output  DATA_WIDTH  final result

Behaviour:
- Reset (async, rst_n low): state=IDLE, counter=0, all internal registers 0, done_o=0, busy_o=0, result_o=0. stall_o is 0 because state=IDLE and it is gated by start_i.
- States:
  - IDLE: waiting for an op.
  - CALC: one iteration per cycle.
  - DONE: result presented for one cycle.
- IDLE:
  - On start_i=1 and flush_i=0, latch funct3, operand magnitudes and sign flags.
  - Divide-by-zero and signed overflow (0x80000000 / -1) go to DONE directly.
  - All other ops go to CALC with counter=DATA_WIDTH.
- CALC:
  - One iteration per cycle; counter decrements each cycle.
  - Leave for DONE when counter reaches 1 (after the last iteration).
- DONE:
  - done_o=1; result_o registered and stable; stall_o=0, so the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. start_i is ignored in DONE because it is still the same instruction.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is combinational so the cycle that presents the op is already stalled.
- Latency:
  - Normal op: 1 IDLE cycle + DATA_WIDTH CALC cycles + 1 DONE cycle. The EX instruction is resident 34 cycles at DATA_WIDTH=32.
  - Special case: 2 cycles (IDLE, then DONE).
- Multiply:
  - Unsigned 2*DATA_WIDTH-bit product from the operand magnitudes.
  - Operand signedness per funct3: MUL/MULH both signed; MULHSU rs1 signed only; MULHU none.
  - Two's-complement negate the full 64-bit product when the sign flags differ.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide:
  - Restoring divide on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated when the operand signs differ; remainder takes the dividend sign.
- Special results:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- flush_i:
  - In any state, flush_i forces IDLE on the next edge with done_o=0 and no result.
  - flush_i wins over start_i in the same cycle: the op is not accepted and stall_o=0.
- Reset mid-operation: returns immediately to reset values; no partial result is ever shown.
- Operand changes while busy are ignored; only latched values are used.

Decomposition:
- core_pkg additions:
  - muldiv_op_e, encoding funct3 values 0..7 (MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU).
  - mdu_state_e (MDU_IDLE, MDU_CALC, MDU_DONE).
  - Constant MDU_CYCLES = DATA_WIDTH.
- Structure:
  - A single module holding the FSM, counter and shared accumulator/shift registers.
  - One natural sub-module: mdu_sign_fix, a combinational magnitude/negate helper instantiated for operand conditioning and result correction.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> stall_o high 33 cycles, done_o for 1 cycle, result_o=0xFFFFFFEB; busy_o low after.
- High-half multiplies:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REMU 100 / 7 -> 2.
- Divide by zero and overflow, each with done_o on the 2nd cycle and stall_o high only on the 1st:
  - DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush and accept priority:
  - Start DIV, assert flush_i at CALC cycle 10 -> IDLE next edge, done_o never asserts, stall_o low.
  - start_i and flush_i together in IDLE -> not accepted.
- rst_n low at CALC cycle 5 -> immediate IDLE with all outputs 0. A subsequent MUL 3*4 -> 12 with normal latency.
